muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle controller and iterative datapath for the RV32M operations (mul, mulh, mulhsu, mulhu, div, divu, rem, remu). It sits beside the combinational ALU in the execute stage and accepts an operation when the ALU control code selects an M-extension op. It stalls the pipeline via `busy` until a one-cycle `done` pulse returns the 32-bit result. Latency is fixed for every operand value, so the hazard logic is unaffected by operand data.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `AluControl`  in  5  operation code, shared ALU encoding 5'b01011..5'b10010
- `a`  in  32  operand rs1 (multiplicand / dividend)
- `b`  in  32  operand rs2 (multiplier / divisor)
- `kill`  in  1  synchronous abort (pipeline flush)
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse; `result` is valid while high
- `result`  out  32  registered result; holds its value until the next `done`
- `div_by_zero`  out  1  registered with `done`; set for div/divu/rem/remu with b == 0

## Operation
- Op codes: 01011 mul (low 32), 01100 mulh (s×s high), 01101 mulhsu (s×u high), 01110 mulhu (u×u high), 01111 div, 10000 divu, 10001 rem, 10010 remu.
- FSM states: IDLE → PREP → CALC → FIX → DONE → IDLE.
- IDLE: `start`=1 with a valid M op captures op, a and b, and moves to PREP. A non-M code is ignored and the block stays IDLE.
- PREP:
  - Convert signed operands to magnitudes, per op: a signed for mulh, mulhsu, div, rem; b signed for mulh, div, rem.
  - Record the result sign.
  - Clear the 64-bit accumulator and the 6-bit counter.
- CALC: 32 iterations, counter 0..31, one per cycle.
  - Multiply: shift-add, 64-bit product.
  - Divide: restoring division, 32-bit quotient and 33-bit partial remainder.
- FIX: apply special cases, then sign correction.
  - Product: negate the 64-bit product if the signs differ.
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = a. Applies to signed and unsigned forms.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Select the low or high word, or the quotient or remainder, into `result`.
- DONE: `done`=1 for this cycle only, then return to IDLE.
- `kill`=1 in any state: next edge goes to IDLE with no `done` pulse. `result` and `div_by_zero` keep their previous values. `kill` has priority over `start`.
- `start` while busy is ignored; there is no queuing.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, `div_by_zero`=0, counter 0.
- `start` sampled at edge N:
  - `busy`=1 after edge N.
  - PREP occupies the cycle after N.
  - CALC occupies edges N+2..N+33.
  - FIX is evaluated at edge N+34.
  - `done`=1 in the cycle after edge N+34.
  - IDLE after edge N+35.
- Fixed latency of 35 cycles from the accepting edge to the `done` cycle, for every op and every operand value, including divide by zero and overflow.
- Back-to-back: a `start` in the cycle after the `done` cycle is accepted. A `start` during the DONE cycle is ignored.
- `rst_n` low mid-operation: immediate asynchronous return to the reset values; no `done`.
- Arithmetic is modulo 2^32 on `result`; all intermediate widths are as stated above, with no truncation before FIX.

## Structure
- Shared package `alu_pkg`:
  - The 5-bit op localparams, reused by the ALU and the decoder.
  - The FSM state encoding.
  - `MULDIV_ITERS` = 32.
- The FSM, counter and sign bookkeeping live in the top module.
- One sub-module, `muldiv_step`: a combinational single-iteration step (shift-add or restore-subtract), selected by a mode bit.

## Test plan
- mul: a = 7, b = 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB, `done` exactly 35 cycles after `start`.
- mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; mulh same operands → 0x00000000; mulhsu a = 0xFFFFFFFF, b = 2 → 0xFFFFFFFF.
- div −7/2 → 0xFFFFFFFD; rem → 0xFFFFFFFF; divu 100/7 → 14; remu → 2.
- Special cases:
  - divu 5/0 → 0xFFFFFFFF with `div_by_zero`=1.
  - rem 5/0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem of the same operands → 0.
- Abort and retry:
  - `kill` at CALC iteration 10 → IDLE next cycle, no `done`, `result` unchanged.
  - A `start` 3 cycles into the following operation is ignored; only one `done` is produced.
- `rst_n` pulsed low during CALC → all outputs 0 immediately; a new mul issued after release completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/M-extension definitions: op codes, sequencer state encoding
// and decode helpers used by the ALU, the decoder and the mul/div sequencer.
package alu_pkg;

    localparam int XLEN         = 32;
    localparam int MULDIV_ITERS = 32;
    localparam logic [5:0] MULDIV_LAST = 6'(MULDIV_ITERS - 1);

    localparam logic [4:0] ALU_MUL    = 5'b01011;
    localparam logic [4:0] ALU_MULH   = 5'b01100;
    localparam logic [4:0] ALU_MULHSU = 5'b01101;
    localparam logic [4:0] ALU_MULHU  = 5'b01110;
    localparam logic [4:0] ALU_DIV    = 5'b01111;
    localparam logic [4:0] ALU_DIVU   = 5'b10000;
    localparam logic [4:0] ALU_REM    = 5'b10001;
    localparam logic [4:0] ALU_REMU   = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

    function automatic logic is_m_op(input logic [4:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REMU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] code);
        return (code >= ALU_DIV) && (code <= ALU_REMU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
interface muldiv_sequencer_if;
    import alu_pkg::*;

    logic            start;
    logic [4:0]      AluControl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            div_by_zero;

    modport master (
        output start, AluControl, a, b, kill,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, AluControl, a, b, kill,
        output busy, done, result, div_by_zero
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath: shift-add multiply (div_mode=0)
// or restoring divide (div_mode=1) on a {high, low} 64-bit accumulator.
module muldiv_step
    import alu_pkg::*;
(
    input  logic        div_mode,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum_s;
    logic [32:0] rem_sh_s;
    logic        rem_ge_s;
    logic [31:0] rem_sub_s;

    // Multiply keeps the multiplier in the low half and shifts the product in
    // from the top; divide shifts the dividend out of the low half into the
    // 33-bit partial remainder and shifts quotient bits in at bit 0.
    always_comb begin
        sum_s     = {1'b0, acc_i[63:32]} + {1'b0, opnd_i};
        rem_sh_s  = acc_i[63:31];
        rem_ge_s  = (rem_sh_s >= {1'b0, opnd_i});
        rem_sub_s = rem_sh_s[31:0] - opnd_i;
        acc_o     = acc_i;
        if (div_mode) begin
            if (rem_ge_s) begin
                acc_o = {rem_sub_s, acc_i[30:0], 1'b1};
            end else begin
                acc_o = {rem_sh_s[31:0], acc_i[30:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {sum_s, acc_i[31:1]};
            end else begin
                acc_o = {1'b0, acc_i[63:32], acc_i[31:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Fixed-latency RV32M multiply/divide sequencer: captures an M op, runs 32
// shift-add or restoring-divide iterations, then applies sign/special fixes.
module muldiv_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);

    muldiv_state_e state_q, state_d;
    logic [4:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   opnd_q, opnd_d;
    logic [63:0]   acc_q, acc_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic          rem_neg_q, rem_neg_d;
    logic          busy_q;
    logic          done_q, done_d;
    logic [31:0]   result_q, result_d;
    logic          dbz_q, dbz_d;

    logic          div_mode_s;
    logic [63:0]   step_acc_s;
    logic          a_neg_s;
    logic          b_neg_s;
    logic [31:0]   mag_a_s;
    logic [31:0]   mag_b_s;
    logic [63:0]   prod_s;
    logic [31:0]   quot_s;
    logic [31:0]   rem_s;
    logic          b_zero_s;
    logic          ovf_s;
    logic [31:0]   fix_result_s;

    assign div_mode_s = is_div_op(op_q);

    muldiv_step u_step (
        .div_mode (div_mode_s),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc_s)
    );

    // Operand magnitudes for PREP; signedness of each operand depends on the op.
    always_comb begin
        a_neg_s = a_q[31] && ((op_q == ALU_MULH) || (op_q == ALU_MULHSU) ||
                              (op_q == ALU_DIV)  || (op_q == ALU_REM));
        b_neg_s = b_q[31] && ((op_q == ALU_MULH) || (op_q == ALU_DIV) ||
                              (op_q == ALU_REM));
        mag_a_s = a_neg_s ? (32'h0000_0000 - a_q) : a_q;
        mag_b_s = b_neg_s ? (32'h0000_0000 - b_q) : b_q;
    end

    // FIX stage: sign correction, divide special cases and word selection.
    always_comb begin
        prod_s       = neg_q ? (64'h0 - acc_q) : acc_q;
        quot_s       = neg_q ? (32'h0000_0000 - acc_q[31:0]) : acc_q[31:0];
        rem_s        = rem_neg_q ? (32'h0000_0000 - acc_q[63:32]) : acc_q[63:32];
        b_zero_s     = (b_q == 32'h0000_0000);
        ovf_s        = ((op_q == ALU_DIV) || (op_q == ALU_REM)) &&
                       (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        fix_result_s = 32'h0000_0000;
        case (op_q)
            ALU_MUL:                        fix_result_s = prod_s[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_result_s = prod_s[63:32];
            ALU_DIV, ALU_DIVU:              fix_result_s = b_zero_s ? 32'hFFFF_FFFF :
                                                           ovf_s    ? 32'h8000_0000 : quot_s;
            ALU_REM, ALU_REMU:              fix_result_s = b_zero_s ? a_q :
                                                           ovf_s    ? 32'h0000_0000 : rem_s;
            default:                        fix_result_s = 32'h0000_0000;
        endcase
    end

    // Next-state and datapath update; kill overrides everything and leaves
    // the visible result untouched.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        result_d  = result_q;
        dbz_d     = dbz_q;
        if (bus.kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && is_m_op(bus.AluControl)) begin
                        state_d = ST_PREP;
                        op_d    = bus.AluControl;
                        a_d     = bus.a;
                        b_d     = bus.b;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREP: begin
                    state_d   = ST_CALC;
                    // Low half carries the multiplier or dividend; high half starts at zero.
                    acc_d     = div_mode_s ? {32'h0000_0000, mag_a_s} : {32'h0000_0000, mag_b_s};
                    opnd_d    = div_mode_s ? mag_b_s : mag_a_s;
                    cnt_d     = 6'd0;
                    neg_d     = a_neg_s ^ b_neg_s;
                    rem_neg_d = a_neg_s;
                end
                ST_CALC: begin
                    acc_d   = step_acc_s;
                    cnt_d   = cnt_q + 6'd1;
                    state_d = (cnt_q == MULDIV_LAST) ? ST_FIX : ST_CALC;
                end
                ST_FIX: begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = fix_result_s;
                    dbz_d    = div_mode_s && b_zero_s;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 5'd0;
            a_q       <= 32'h0000_0000;
            b_q       <= 32'h0000_0000;
            opnd_q    <= 32'h0000_0000;
            acc_q     <= 64'h0;
            cnt_q     <= 6'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'h0000_0000;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops against a
// native-arithmetic reference, and abort/reset/ignored-start sequences.
module tb_muldiv_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          acc_cyc;
    } exp_t;

    // done is seen after the edge 34 edges past the accepting edge
    localparam int DONE_OFS = 34;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks;
    int   errors;
    int   done_cnt;
    logic [31:0] last_res;
    exp_t sb[$];
    vec_t vecs[12];

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] av,
                                            input logic [31:0] bv);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic signed [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic ovf;
        sa  = av;
        sbv = bv;
        ovf = (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
        case (op)
            ALU_MUL:    begin x = {32'h0, av}; y = {32'h0, bv}; p = x * y; return p[31:0]; end
            ALU_MULH:   begin x = {{32{av[31]}}, av}; y = {{32{bv[31]}}, bv}; p = x * y; return p[63:32]; end
            ALU_MULHSU: begin x = {{32{av[31]}}, av}; y = {32'h0, bv}; p = x * y; return p[63:32]; end
            ALU_MULHU:  begin x = {32'h0, av}; y = {32'h0, bv}; p = x * y; return p[63:32]; end
            ALU_DIV:    return (bv == 32'h0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sbv);
            ALU_DIVU:   return (bv == 32'h0) ? 32'hFFFF_FFFF : av / bv;
            ALU_REM:    return (bv == 32'h0) ? av : ovf ? 32'h0 : 32'(sa % sbv);
            ALU_REMU:   return (bv == 32'h0) ? av : av % bv;
            default:    return 32'h0;
        endcase
    endfunction

    // Drive one request for a cycle; push the expectation if it should be accepted.
    task automatic issue(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic ed, input bit accept);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.AluControl = op;
        bus.a = av;
        bus.b = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (accept) begin
            e.res = er;
            e.dbz = ed;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        chk(accept ? "busy_after_accept" : "busy_after_ignored", {31'h0, bus.busy}, {31'h0, accept});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int d0;
        logic [4:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        last_res = 32'h0;
        bus.start = 1'b0;
        bus.AluControl = 5'd0;
        bus.a = 32'h0;
        bus.b = 32'h0;
        bus.kill = 1'b0;
        rst_n = 1'b0;

        vecs[0]  = '{ALU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{ALU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{ALU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{ALU_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
        vecs[7]  = '{ALU_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0};
        vecs[8]  = '{ALU_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{ALU_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1};
        vecs[10] = '{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[11] = '{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

        // Response monitor: every done pulse must match the oldest expectation.
        fork
            forever begin
                exp_t e;
                @(posedge clk);
                #1;
                if (bus.done === 1'b1) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done result=%h required=no_done", bus.result);
                    end else begin
                        e = sb.pop_front();
                        chk("result", bus.result, e.res);
                        chk("div_by_zero", {31'h0, bus.div_by_zero}, {31'h0, e.dbz});
                        chk("latency", 32'(cyc - e.acc_cyc), 32'(DONE_OFS));
                        last_res = e.res;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'h0, bus.busy}, 32'h0);
        chk("reset_done", {31'h0, bus.done}, 32'h0);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_dbz", {31'h0, bus.div_by_zero}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(5'b00000, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0);

        // Table vectors, issued back-to-back in the cycle after each done.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz, 1'b1);
            wait_done();
            @(posedge clk);
        end

        // start during the DONE cycle is dropped
        issue(ALU_MUL, 32'h3, 32'h5, 32'hF, 1'b0, 1'b1);
        wait_done();
        issue(ALU_DIVU, 32'h9, 32'h3, 32'h3, 1'b0, 1'b0);

        // kill at CALC iteration 10
        issue(ALU_MULHU, 32'h10, 32'h20, 32'h0, 1'b0, 1'b1);
        sb.delete();
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        chk("kill_busy", {31'h0, bus.busy}, 32'h0);
        chk("kill_done", {31'h0, bus.done}, 32'h0);
        chk("kill_result", bus.result, last_res);
        @(negedge clk);
        bus.kill = 1'b0;
        d0 = done_cnt;
        repeat (45) @(posedge clk);
        #2;
        chk("kill_no_done", 32'(done_cnt), 32'(d0));

        // start three cycles into an op is ignored
        issue(ALU_MUL, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 1'b1);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.AluControl = ALU_DIVU;
        bus.a = 32'h64;
        bus.b = 32'h5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (40) @(posedge clk);
        #2;
        chk("single_done", 32'(done_cnt), 32'(d0 + 1));

        // asynchronous reset during CALC, then a fresh op
        issue(ALU_MUL, 32'h0000_0100, 32'h0000_0100, 32'h0001_0000, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_dbz", {31'h0, bus.div_by_zero}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(ALU_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 1'b1);
        wait_done();
        @(posedge clk);

        // random ops against the native-arithmetic reference
        for (int i = 0; i < 12; i++) begin
            rop = 5'(ALU_MUL + 5'($urandom_range(7, 0)));
            ra  = $urandom;
            rb  = ($urandom_range(3, 0) == 0) ? 32'h0 : $urandom;
            issue(rop, ra, rb, ref_res(rop, ra, rb), is_div_op(rop) && (rb == 32'h0), 1'b1);
            wait_done();
            @(posedge clk);
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
